// File: rtl/dmem_img_reader_pkg.sv
// Shared constants, state encoding and address helper for the DMEM image reader.
// Optional checksum byte is enabled by defining IMG_RD_CHKSUM_EN.
package img_rd_pkg;

  localparam int PIX_PER_WORD = 32;
  localparam int IMG_WORDS    = 25;
  localparam int PIX_W        = 8;
  localparam int WORD_W       = PIX_PER_WORD * PIX_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5
  } rd_state_t;

  // Word address arithmetic is 7-bit and wraps modulo 128.
  function automatic logic [6:0] word_addr(input logic [6:0] base, input logic [4:0] idx);
    return base + {2'b00, idx};
  endfunction

endpackage

// File: rtl/dmem_img_reader_word_unpacker.sv
// Holds one 256-bit DMEM word and presents it a byte at a time, pixel 0 first.
module word_unpacker
  import img_rd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  output logic [PIX_W-1:0]  byte_out,
  output logic              last_byte
);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [4:0]        byte_idx_q, byte_idx_d;

  always_comb begin
    shreg_d    = shreg_q;
    byte_idx_d = byte_idx_q;
    if (load) begin
      shreg_d    = din;
      byte_idx_d = '0;
    end else if (shift) begin
      shreg_d    = {{PIX_W{1'b0}}, shreg_q[WORD_W-1:PIX_W]};
      byte_idx_d = byte_idx_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q    <= '0;
      byte_idx_q <= '0;
    end else begin
      shreg_q    <= shreg_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  assign byte_out  = shreg_q[PIX_W-1:0];
  assign last_byte = (byte_idx_q == 5'(PIX_PER_WORD - 1));

endmodule

// File: rtl/dmem_img_reader.sv
// Streams the 28x28 frame from DMEM as raster-order bytes over valid/ready.
// Define IMG_RD_CHKSUM_EN to append a modulo-256 pixel checksum byte.
module dmem_img_reader
  import img_rd_pkg::*;
#(
  parameter logic [6:0] BASE_ADDR  = 7'd0,
  parameter int         RD_LATENCY = 1,
  parameter int         NUM_PIXELS = 784
) (
  input  logic         CLOCK_50,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         dmem_rden,
  output logic [6:0]   dmem_rdaddr,
  input  logic [255:0] dmem_rddata,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [2:0]   dbg_state
);

  // tx handshake: a byte moves on a cycle where tx_valid and tx_ready are both
  // high; once raised, tx_valid and tx_data hold until that cycle.
  rd_state_t  state_q;
  logic [4:0] word_cnt_q;
  logic [9:0] pix_cnt_q;
  logic [1:0] lat_q;
  logic       busy_q, done_q, rden_q, tx_valid_q;
  logic [6:0] rdaddr_q;
`ifdef IMG_RD_CHKSUM_EN
  logic [7:0] csum_q;
`endif

  logic       hs, load, shift, last_pix, last_byte;
  logic [7:0] pix_byte;

  assign hs       = tx_valid_q & tx_ready;
  assign load     = (state_q == WAIT) && (lat_q == 2'(RD_LATENCY));
  assign shift    = hs && (state_q == SEND);
  assign last_pix = (pix_cnt_q == 10'(NUM_PIXELS - 1));

  word_unpacker u_unpack (
    .clk       (CLOCK_50),
    .rst_n     (rst_n),
    .load      (load),
    .shift     (shift),
    .din       (dmem_rddata),
    .byte_out  (pix_byte),
    .last_byte (last_byte)
  );

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      pix_cnt_q  <= '0;
      lat_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rden_q     <= 1'b0;
      rdaddr_q   <= '0;
      tx_valid_q <= 1'b0;
`ifdef IMG_RD_CHKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      case (state_q)
        // DONE behaves like IDLE for start so back-to-back frames need no gap.
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q    <= REQ;
            word_cnt_q <= '0;
            pix_cnt_q  <= '0;
            busy_q     <= 1'b1;
            rden_q     <= 1'b1;
            rdaddr_q   <= word_addr(BASE_ADDR, 5'd0);
`ifdef IMG_RD_CHKSUM_EN
            csum_q     <= '0;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        REQ: begin
          rden_q  <= 1'b0;
          lat_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (load) begin
            tx_valid_q <= 1'b1;
            state_q    <= SEND;
          end else begin
            lat_q <= lat_q + 2'd1;
          end
        end
        SEND: begin
          if (hs) begin
            pix_cnt_q <= pix_cnt_q + 10'd1;
`ifdef IMG_RD_CHKSUM_EN
            csum_q    <= csum_q + pix_byte;
`endif
            if (last_pix) begin
`ifdef IMG_RD_CHKSUM_EN
              state_q <= CSUM;
`else
              tx_valid_q <= 1'b0;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= DONE;
`endif
            end else if (last_byte) begin
              word_cnt_q <= word_cnt_q + 5'd1;
              rden_q     <= 1'b1;
              rdaddr_q   <= word_addr(BASE_ADDR, word_cnt_q + 5'd1);
              tx_valid_q <= 1'b0;
              state_q    <= REQ;
            end
          end
        end
`ifdef IMG_RD_CHKSUM_EN
        CSUM: begin
          if (hs) begin
            tx_valid_q <= 1'b0;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= DONE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign dmem_rden   = rden_q;
  assign dmem_rdaddr = rdaddr_q;
  assign tx_valid    = tx_valid_q;
  assign dbg_state   = state_q;
`ifdef IMG_RD_CHKSUM_EN
  assign tx_data     = (state_q == CSUM) ? csum_q : pix_byte;
`else
  assign tx_data     = pix_byte;
`endif

endmodule

// File: tb/tb_dmem_img_reader.sv
// Bench for dmem_img_reader: two instances (base 0 / latency 1, base 120 / latency 3)
// with behavioural DMEM models, a byte/address scoreboard and directed frame runs.
module tb_dmem_img_reader;

  localparam int NPIX = 784;
`ifdef IMG_RD_CHKSUM_EN
  localparam int NBYTES = NPIX + 1;
`else
  localparam int NBYTES = NPIX;
`endif

  typedef struct {
    int g;
    int pat;
    int rdy;
    int exp_lat;
    int exp_bytes;
    int exp_rden;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       tx_ready;
  logic       start     [2];
  logic       busy      [2];
  logic       done      [2];
  logic       rden      [2];
  logic       tx_valid  [2];
  logic [6:0] rdaddr    [2];
  logic [7:0] tx_data   [2];
  logic [2:0] dbg_state [2];

  int cur_pat = 0;
  int rdy_mode = 0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [6:0] exp_a_q[$];

  int   hs_cnt[2], rden_cnt[2], done_cnt[2], last_hs_cyc[2], first_v_cyc[2], start_cyc[2];
  logic prev_stall[2], prev_done[2], prev_rden[2];
  logic [7:0] prev_data[2];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // ---------------- image model ----------------
  function automatic logic [7:0] pix(input int pat, input int i);
    case (pat)
      0:       return 8'(i);
      1:       return 8'hFF;
      default: return 8'(i * 7 + 3);
    endcase
  endfunction

  function automatic logic [255:0] mk_word(input logic [6:0] base, input logic [6:0] a);
    logic [255:0] w;
    logic [6:0]   off;
    int           wi, i;
    off = a - base;
    wi  = int'(off);
    w   = '0;
    for (int k = 0; k < 32; k++) begin
      i = wi * 32 + k;
      w[8*k +: 8] = (wi < 25 && i < NPIX) ? pix(cur_pat, i) : 8'hEE;
    end
    return w;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int         LAT  = (g == 0) ? 1 : 3;
    localparam logic [6:0] BASE = (g == 0) ? 7'd0 : 7'd120;
    logic [255:0] rd_q = '0;
    logic [6:0]   a_q  = '0;
    int           dly  = 0;

    dmem_img_reader #(
      .BASE_ADDR  (BASE),
      .RD_LATENCY (LAT),
      .NUM_PIXELS (NPIX)
    ) u_dut (
      .CLOCK_50    (clk),
      .rst_n       (rst_n),
      .start       (start[g]),
      .busy        (busy[g]),
      .done        (done[g]),
      .dmem_rden   (rden[g]),
      .dmem_rdaddr (rdaddr[g]),
      .dmem_rddata (rd_q),
      .tx_data     (tx_data[g]),
      .tx_valid    (tx_valid[g]),
      .tx_ready    (tx_ready),
      .dbg_state   (dbg_state[g])
    );

    // Data appears LAT edges after the edge that samples rden, then holds.
    always @(posedge clk) begin
      if (rden[g]) begin
        a_q = rdaddr[g];
        dly = LAT;
      end
      if (dly != 0) begin
        dly = dly - 1;
        if (dly == 0) rd_q <= mk_word(BASE, a_q);
      end
    end
  end

  // ---------------- sink ready pattern ----------------
  initial begin
    int r;
    r = 0;
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      r++;
      if (rdy_mode == 0) tx_ready = 1'b1;
      else tx_ready = ((r % 97) >= 20) && ((r % 3) == 0);
    end
  end

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        check("reset_outputs", int'({busy[g], done[g], rden[g], tx_valid[g],
                                     rdaddr[g], tx_data[g], dbg_state[g]}), 0);
        prev_stall[g] = 1'b0;
        prev_done[g]  = 1'b0;
        prev_rden[g]  = 1'b0;
      end else begin
        if (prev_stall[g]) begin
          check("stall_valid_held", int'(tx_valid[g]), 1);
          check("stall_data_stable", int'(tx_data[g]), int'(prev_data[g]));
        end
        if (tx_valid[g]) check("busy_while_valid", int'(busy[g]), 1);
        if (tx_valid[g] && tx_ready) begin
          hs_cnt[g]++;
          last_hs_cyc[g] = cyc;
          check("tx_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) check("tx_data", int'(tx_data[g]), int'(exp_q.pop_front()));
        end
        if (rden[g]) begin
          rden_cnt[g]++;
          check("rden_during_valid", int'(tx_valid[g]), 0);
          check("rden_single_cycle", int'(prev_rden[g]), 0);
          check("rden_expected", int'(exp_a_q.size() > 0), 1);
          if (exp_a_q.size() > 0) check("rdaddr", int'(rdaddr[g]), int'(exp_a_q.pop_front()));
        end
        if (done[g]) begin
          done_cnt[g]++;
          check("done_single_cycle", int'(prev_done[g]), 0);
          check("done_after_last_hs", cyc - last_hs_cyc[g], 1);
          check("busy_low_at_done", int'(busy[g]), 0);
        end
        if (tx_valid[g] && first_v_cyc[g] < 0) first_v_cyc[g] = cyc;
        prev_stall[g] = tx_valid[g] && !tx_ready;
        prev_data[g]  = tx_data[g];
        prev_rden[g]  = rden[g];
        prev_done[g]  = done[g];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame(input int g);
    logic [6:0] base, a;
`ifdef IMG_RD_CHKSUM_EN
    logic [7:0] sum;
    sum = '0;
`endif
    base = (g == 0) ? 7'd0 : 7'd120;
    for (int i = 0; i < NPIX; i++) begin
      exp_q.push_back(pix(cur_pat, i));
`ifdef IMG_RD_CHKSUM_EN
      sum = sum + pix(cur_pat, i);
`endif
    end
`ifdef IMG_RD_CHKSUM_EN
    exp_q.push_back(sum);
`endif
    for (int w = 0; w < 25; w++) begin
      a = base + 7'(w);
      exp_a_q.push_back(a);
    end
  endtask

  task automatic prep_frame(input int g);
    exp_q.delete();
    exp_a_q.delete();
    hs_cnt[g]      = 0;
    rden_cnt[g]    = 0;
    done_cnt[g]    = 0;
    first_v_cyc[g] = -1;
    push_frame(g);
  endtask

  task automatic pulse_start(input int g);
    @(posedge clk);
    #1;
    start[g] = 1'b1;
    @(posedge clk);
    #1;
    start_cyc[g] = cyc;
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int target);
    int n;
    n = 0;
    while (done_cnt[g] < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done_cnt[g], target);
  endtask

  task automatic wait_bytes(input int g, input int nb);
    int n;
    n = 0;
    while (hs_cnt[g] < nb && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("bytes_reached", int'(hs_cnt[g] >= nb), 1);
  endtask

  task automatic end_checks(input int g, input int bytes, input int rdens, input int dones);
    repeat (8) @(negedge clk);
    check("byte_count", hs_cnt[g], bytes);
    check("rden_count", rden_cnt[g], rdens);
    check("done_count", done_cnt[g], dones);
    check("bytes_left", exp_q.size(), 0);
    check("addrs_left", exp_a_q.size(), 0);
    check("busy_idle", int'(busy[g]), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs[5];
    int   n;

    vecs[0] = '{g: 0, pat: 0, rdy: 0, exp_lat: 3, exp_bytes: NBYTES, exp_rden: 25};
    vecs[1] = '{g: 0, pat: 0, rdy: 1, exp_lat: 3, exp_bytes: NBYTES, exp_rden: 25};
    vecs[2] = '{g: 1, pat: 0, rdy: 0, exp_lat: 5, exp_bytes: NBYTES, exp_rden: 25};
    vecs[3] = '{g: 0, pat: 1, rdy: 0, exp_lat: 3, exp_bytes: NBYTES, exp_rden: 25};
    vecs[4] = '{g: 1, pat: 2, rdy: 1, exp_lat: 5, exp_bytes: NBYTES, exp_rden: 25};

    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      start[g]       = 1'b0;
      hs_cnt[g]      = 0;
      rden_cnt[g]    = 0;
      done_cnt[g]    = 0;
      last_hs_cyc[g] = 0;
      first_v_cyc[g] = -1;
      start_cyc[g]   = 0;
      prev_stall[g]  = 1'b0;
      prev_done[g]   = 1'b0;
      prev_rden[g]   = 1'b0;
      prev_data[g]   = '0;
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      cur_pat  = vecs[v].pat;
      rdy_mode = vecs[v].rdy;
      prep_frame(vecs[v].g);
      pulse_start(vecs[v].g);
      wait_done(vecs[v].g, 1);
      end_checks(vecs[v].g, vecs[v].exp_bytes, vecs[v].exp_rden, 1);
      check("first_valid_latency", first_v_cyc[vecs[v].g] - start_cyc[vecs[v].g], vecs[v].exp_lat);
    end

    // start while busy is ignored
    cur_pat  = 0;
    rdy_mode = 0;
    prep_frame(0);
    pulse_start(0);
    wait_bytes(0, 100);
    pulse_start(0);
    wait_done(0, 1);
    repeat (60) @(negedge clk);
    end_checks(0, NBYTES, 25, 1);

    // start coinciding with done launches the next frame at once
    cur_pat  = 2;
    rdy_mode = 1;
    prep_frame(0);
    push_frame(0);
    pulse_start(0);
    n = 0;
    while (!done[0] && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("done_reached", int'(done[0]), 1);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    check("busy_after_done_start", int'(busy[0]), 1);
    check("rden_after_done_start", int'(rden[0]), 1);
    wait_done(0, 2);
    end_checks(0, 2 * NBYTES, 50, 2);

    // reset mid-frame, then a clean frame from pixel 0
    cur_pat  = 0;
    rdy_mode = 0;
    prep_frame(0);
    pulse_start(0);
    wait_bytes(0, 400);
    #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("no_done_on_reset", done_cnt[0], 0);
    check("idle_after_reset", int'(busy[0]), 0);
    cur_pat = 1;
    prep_frame(0);
    pulse_start(0);
    wait_done(0, 1);
    end_checks(0, NBYTES, 25, 1);
    check("first_valid_after_reset", first_v_cyc[0] - start_cyc[0], 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
